// File: rtl/mult_pkg.sv
// Shared types and sizing for the 8-bit signed shift-add multiplier.
package mult_pkg;
    localparam int WIDTH      = 8;
    localparam int ITERATIONS = 8;
    localparam int LAST_ITER  = ITERATIONS - 1;
    localparam int ITER_W     = $clog2(ITERATIONS);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/mult_sequencer_if.sv
// Start/busy/done handshake plus operand and result bus of the multiplier.
interface mult_sequencer_if;
    import mult_pkg::*;

    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   x_sign;

    modport master (output start, multiplicand, multiplier,
                    input  busy, done, product, x_sign);
    modport slave  (input  start, multiplicand, multiplier,
                    output busy, done, product, x_sign);
endinterface

// File: rtl/mult_addsub9.sv
// Combinational 9-bit ripple add/subtract of two sign-extended 8-bit operands.
module mult_addsub9
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] op_a;
    logic [WIDTH:0] op_b;
    logic [WIDTH:0] carry;

    assign op_a     = {a[WIDTH-1], a};
    assign op_b     = {b[WIDTH-1], b} ^ {(WIDTH+1){sub}};
    assign carry[0] = sub;

    // Carry out of the top bit is dropped, so no stage computes it.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum[i] = op_a[i] ^ op_b[i] ^ carry[i];
        if (i < WIDTH) begin : g_carry
            assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
        end
    end
endmodule

// File: rtl/mult_sequencer.sv
// FSM that steps X:A:B through eight add/shift iterations; the last add subtracts.
module mult_sequencer
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    mult_sequencer_if.slave  bus
);
    state_t              state_q;
    logic                x_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    s_q;
    logic [ITER_W-1:0]   iter_q;
    logic                busy_q;
    logic                done_q;

    logic                last_iter;
    logic [WIDTH:0]      sum_d;

    assign last_iter = (iter_q == ITER_W'(LAST_ITER));

    // Multiplier MSB carries negative weight, so its partial product is subtracted.
    mult_addsub9 u_addsub (
        .a   (a_q),
        .b   (s_q),
        .sub (last_iter),
        .sum (sum_d)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    x_q     <= 1'b0;
                    a_q     <= '0;
                    b_q     <= bus.multiplier;
                    s_q     <= bus.multiplicand;
                    iter_q  <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ADD;
                end
                ADD: begin
                    if (b_q[0]) {x_q, a_q} <= sum_d;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    a_q    <= {x_q, a_q[WIDTH-1:1]};
                    b_q    <= {a_q[0], b_q[WIDTH-1:1]};
                    iter_q <= iter_q + ITER_W'(1);
                    if (last_iter) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        state_q <= ADD;
                    end
                end
                // A held-high start must drop before another operation is accepted.
                HOLD: if (!bus.start) begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = {a_q, b_q};
    assign bus.x_sign  = x_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench: directed vector table, handshake corner cases, random operands.
module tb_mult_sequencer;
    logic Clk;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    mult_sequencer_if bus ();

    mult_sequencer dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [7:0]  mc;
        logic [7:0]  mp;
        logic [15:0] prod;
        logic        xs;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain signed integer multiply; X is the sign of the true product.
    function automatic logic [16:0] ref_mul(input logic [7:0] mc, input logic [7:0] mp);
        int p;
        p = int'($signed(mc)) * int'($signed(mp));
        return {p < 0, p[15:0]};
    endfunction

    // One operation from an idle start: cycle 0 accept, busy 1..16, done 17.
    // extra > 0 keeps start high that many cycles past done to test no-retrigger.
    task automatic do_op(input logic [7:0] mc, input logic [7:0] mp,
                         input logic [15:0] ep, input logic ex, input int extra);
        @(negedge Clk);
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        for (int c = 1; c <= 16; c++) begin
            @(negedge Clk);
            chk($sformatf("busy/done c%0d", c), {30'd0, bus.busy, bus.done}, 32'h2);
            if (extra == 0) bus.start = 1'b0;
            bus.multiplicand = 8'($urandom);
            bus.multiplier   = 8'($urandom);
        end
        @(negedge Clk);
        chk("busy/done c17", {30'd0, bus.busy, bus.done}, 32'h1);
        chk("product", {16'd0, bus.product}, {16'd0, ep});
        chk("x_sign", {31'd0, bus.x_sign}, {31'd0, ex});
        for (int e = 1; e <= extra; e++) begin
            @(negedge Clk);
            chk("hold done", {30'd0, bus.busy, bus.done}, 32'h1);
            chk("hold product", {16'd0, bus.product}, {16'd0, ep});
        end
        bus.start = 1'b0;
        @(negedge Clk);
        chk("idle done", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("idle product kept", {16'd0, bus.product}, {16'd0, ep});
    endtask

    initial begin
        logic [16:0] r;
        logic [7:0]  mc, mp;

        vecs[0] = '{8'h07, 8'h03, 16'h0015, 1'b0};
        vecs[1] = '{8'hFB, 8'h07, 16'hFFDD, 1'b1};
        vecs[2] = '{8'h05, 8'hFD, 16'hFFF1, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 16'h4000, 1'b0};
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
        vecs[5] = '{8'h00, 8'h80, 16'h0000, 1'b0};
        vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1'b1};

        Reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = 8'h00;
        bus.multiplier   = 8'h00;
        #12;
        chk("reset busy/done", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("reset product", {16'd0, bus.product}, 32'h0);
        chk("reset x_sign", {31'd0, bus.x_sign}, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].mc, vecs[i].mp, vecs[i].prod, vecs[i].xs, 0);

        // Start held for 40 cycles: one operation only, then a fresh one after start drops.
        do_op(8'h02, 8'h03, 16'h0006, 1'b0, 23);
        do_op(8'h04, 8'hFD, 16'hFFF4, 1'b1, 0);

        // Reset in cycle 8 of 0x7F x 0x7F clears everything immediately.
        @(negedge Clk);
        bus.start        = 1'b1;
        bus.multiplicand = 8'h7F;
        bus.multiplier   = 8'h7F;
        for (int c = 1; c <= 8; c++) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midrst busy/done", {30'd0, bus.busy, bus.done}, 32'h0);
        chk("midrst product", {16'd0, bus.product}, 32'h0);
        chk("midrst x_sign", {31'd0, bus.x_sign}, 32'h0);
        bus.start = 1'b0;
        @(negedge Clk);
        chk("midrst idle", {30'd0, bus.busy, bus.done}, 32'h0);
        Reset_n = 1'b1;
        do_op(8'h7F, 8'h7F, 16'h3F01, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            mc = 8'($urandom);
            mp = 8'($urandom);
            r  = ref_mul(mc, mp);
            do_op(mc, mp, r[15:0], r[16], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
